// File: rtl/uart_byte_receiver.sv
// Oversampling UART byte receiver with a level rx_done / rx_trigger handshake.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check; default is 8N1.
module uart_byte_receiver #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       rx_trigger,
   output logic [7:0] rx_byte,
   output logic       rx_done,
   output logic       frame_err,
   output logic       overrun,
   output logic       parity_err
);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {ARM, IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state_reg, state_next;

   logic        rx_meta, rxs;
   logic [15:0] cnt_reg;
   logic [2:0]  idx_reg;
   logic [7:0]  shift_reg;
   logic        half_tick, bit_tick;
   logic        cnt_clr, data_smp, good_stop, bad_stop;
`ifdef UART_RX_PARITY_EN
   logic        par_smp, par_mis_reg;
`endif

   assign half_tick = (cnt_reg == HALF_LAST);
   assign bit_tick  = (cnt_reg == BIT_LAST);

   // Synchronizer flops reset to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ARM;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ARM:    if (rxs) state_next = IDLE;
         IDLE:   if (!rxs) state_next = START;
         START:  if (half_tick) state_next = rxs ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:   if (bit_tick && idx_reg == 3'd7) state_next = PARITY;
         PARITY: if (bit_tick) state_next = STOP;
`else
         DATA:   if (bit_tick && idx_reg == 3'd7) state_next = STOP;
`endif
         // A low stop bit may be a break; re-arm only once the line returns high.
         STOP:   if (bit_tick) state_next = rxs ? IDLE : ARM;
         default: state_next = ARM;
      endcase
   end

   always_comb begin
      cnt_clr   = 1'b0;
      data_smp  = 1'b0;
      good_stop = 1'b0;
      bad_stop  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_smp   = 1'b0;
`endif
      case (state_reg)
         START: cnt_clr = half_tick;
         DATA: begin
            data_smp = bit_tick;
            cnt_clr  = bit_tick;
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            par_smp = bit_tick;
            cnt_clr = bit_tick;
         end
`endif
         STOP: begin
            good_stop = bit_tick && rxs;
            bad_stop  = bit_tick && !rxs;
         end
         default: cnt_clr = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
      end else begin
         cnt_reg <= cnt_clr ? 16'd0 : cnt_reg + 16'd1;
         if (state_reg != DATA) idx_reg <= 3'd0;
         else if (data_smp)     idx_reg <= idx_reg + 3'd1;
         if (data_smp) shift_reg[idx_reg] <= rxs;
      end
   end

   // A completing good frame takes priority over a consume in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_byte   <= 8'h00;
         rx_done   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else if (good_stop) begin
         rx_byte   <= shift_reg;
         rx_done   <= 1'b1;
         frame_err <= 1'b0;
         overrun   <= rx_done && !rx_trigger;
      end else begin
         if (rx_trigger) begin
            rx_done <= 1'b0;
            overrun <= 1'b0;
         end
         if (bad_stop) frame_err <= 1'b1;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_mis_reg <= 1'b0;
         parity_err  <= 1'b0;
      end else begin
         if (par_smp)   par_mis_reg <= (^shift_reg) ^ rxs;
         if (good_stop) parity_err  <= par_mis_reg;
      end
   end
`else
   assign parity_err = 1'b0;
`endif
endmodule
